// File: rtl/clk_div_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | clk_div_pkg : shared widths, reset divisor and channel-index helper  |
// | Revision    : 1.0                                                    |
// +---------------------------------------------------------------------+
package clk_div_pkg;

  localparam int                     DIV_W_DEF       = 26;
  localparam logic [DIV_W_DEF-1:0]   DEFAULT_DIV_DEF = 26'd2500000;
  localparam int                     NCH_MAX         = 16;

  // Width of a channel index; never narrower than one bit.
  function automatic int chan_w(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | clk_div_chan : one divider channel with boundary-applied divisor     |
// | Optional     : CLK_DIV_MULTI_SYNC_EN adds the sync restart input     |
// | Revision     : 1.0                                                   |
// +---------------------------------------------------------------------+
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               DIV_W       = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic             sync,
`endif
  input  logic             we,
  input  logic [DIV_W-1:0] wdiv,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] nxt_q, nxt_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             w_term;
  logic             apply;

  // cnt only advances below div, so the maximum divisor cannot overflow.
  assign w_term = (cnt_q == div_q);

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    nxt_d     = nxt_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    apply     = 1'b0;
    if (!en) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      apply     = pend_q;
    end
`ifdef CLK_DIV_MULTI_SYNC_EN
    else if (sync) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      apply     = pend_q;
    end
`endif
    else if (w_term) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
      tick_d    = 1'b1;
      apply     = pend_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    if (apply) begin
      div_d  = nxt_q;
      pend_d = 1'b0;
    end
    // A write in the applying cycle stays pending for the next boundary.
    if (we) begin
      nxt_d  = wdiv;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= DEFAULT_DIV;
      nxt_q     <= DEFAULT_DIV;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      nxt_q     <= nxt_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | clk_div_multi : NCH independent programmable clock dividers          |
// | Optional      : CLK_DIV_MULTI_SYNC_EN adds the syncIn port           |
// | Revision      : 1.0                                                  |
// +---------------------------------------------------------------------+
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int               NCH         = 4,
  parameter int               DIV_W       = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEFAULT_DIV_DEF)
) (
  input  logic                     clkIn,
  input  logic                     rstN,
  input  logic [NCH-1:0]           en,
  input  logic                     cfgWe,
  input  logic [chan_w(NCH)-1:0]   cfgChan,
  input  logic [DIV_W-1:0]         cfgDiv,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic                     syncIn,
`endif
  output logic [NCH-1:0]           clkOut,
  output logic [NCH-1:0]           tick,
  output logic [NCH-1:0]           pending
);

  localparam int CW = chan_w(NCH);

  logic [NCH-1:0] w_we;

  // Indices at or above NCH match no channel, so such writes are dropped.
  generate
    for (genvar c = 0; c < NCH; c++) begin : g_chan
      assign w_we[c] = cfgWe && (cfgChan == CW'(c));

      clk_div_chan #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk     (clkIn),
        .rst_n   (rstN),
        .en      (en[c]),
`ifdef CLK_DIV_MULTI_SYNC_EN
        .sync    (syncIn),
`endif
        .we      (w_we[c]),
        .wdiv    (cfgDiv),
        .clk_out (clkOut[c]),
        .tick    (tick[c]),
        .pending (pending[c])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_clk_div_multi : directed scoreboard bench for clk_div_multi       |
// | Optional         : CLK_DIV_MULTI_SYNC_EN enables the syncIn steps    |
// | Revision         : 1.0                                               |
// +---------------------------------------------------------------------+
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int NCH   = 5;
  localparam int DIV_W = 8;
  localparam int CW    = chan_w(NCH);

  logic             clkIn = 1'b0;
  logic             rstN;
  logic [NCH-1:0]   en;
  logic             cfgWe;
  logic [CW-1:0]    cfgChan;
  logic [DIV_W-1:0] cfgDiv;
`ifdef CLK_DIV_MULTI_SYNC_EN
  logic             syncIn;
`endif
  logic [NCH-1:0]   clkOut;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pending;

  clk_div_multi #(
    .NCH         (NCH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (8'd3)
  ) dut (
    .clkIn   (clkIn),
    .rstN    (rstN),
    .en      (en),
    .cfgWe   (cfgWe),
    .cfgChan (cfgChan),
    .cfgDiv  (cfgDiv),
`ifdef CLK_DIV_MULTI_SYNC_EN
    .syncIn  (syncIn),
`endif
    .clkOut  (clkOut),
    .tick    (tick),
    .pending (pending)
  );

  always #5 clkIn = ~clkIn;

  typedef struct packed {
    logic [NCH-1:0] ck;
    logic [NCH-1:0] tk;
    logic [NCH-1:0] pd;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    e     = 0;

  // Per-channel phase reference: after edge rf the channel had count sv, output cv.
  bit act[NCH];
  int dv[NCH], sv[NCH], rf[NCH], plo[NCH], phi[NCH];
  bit cv[NCH];

  function automatic logic f_clk(input int ch, input int x);
    int k;
    if (!act[ch]) return 1'b0;
    k = x - rf[ch];
    return cv[ch] ^ ((((sv[ch] + k) / (dv[ch] + 1)) % 2) == 1);
  endfunction

  function automatic logic f_tick(input int ch, input int x);
    int k;
    if (!act[ch]) return 1'b0;
    k = x - rf[ch];
    return (k > 0) && (((sv[ch] + k) % (dv[ch] + 1)) == 0);
  endfunction

  function automatic logic f_pd(input int ch, input int x);
    return (x >= plo[ch]) && (x < phi[ch]);
  endfunction

  task automatic chk(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  task automatic push_win(input string tag, input int n);
    exp_t it;
    for (int i = 1; i <= n; i++) begin
      for (int c = 0; c < NCH; c++) begin
        it.ck[c] = f_clk(c, e + i);
        it.tk[c] = f_tick(c, e + i);
        it.pd[c] = f_pd(c, e + i);
      end
      exp_q.push_back(it);
      tag_q.push_back($sformatf("%s@%0d", tag, e + i));
    end
  endtask

  task automatic run(input int n);
    exp_t  it;
    string tg;
    repeat (n) begin
      @(posedge clkIn);
      #1;
      e++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL scoreboard_empty: observed no entry expected one at edge %0d", e);
      end else begin
        it = exp_q.pop_front();
        tg = tag_q.pop_front();
        chk({tg, "_clkOut"},  clkOut,  it.ck);
        chk({tg, "_tick"},    tick,    it.tk);
        chk({tg, "_pending"}, pending, it.pd);
      end
    end
  endtask

  task automatic reref(input int ch, input int d);
    cv[ch] = f_clk(ch, e);
    rf[ch] = e;
    sv[ch] = 0;
    dv[ch] = d;
  endtask

  task automatic start(input int ch, input int d);
    act[ch] = 1'b1;
    rf[ch]  = e;
    sv[ch]  = 0;
    cv[ch]  = 1'b0;
    dv[ch]  = d;
  endtask

  initial begin
    rstN    = 1'b0;
    en      = '0;
    cfgWe   = 1'b0;
    cfgChan = '0;
    cfgDiv  = '0;
`ifdef CLK_DIV_MULTI_SYNC_EN
    syncIn  = 1'b0;
`endif
    for (int c = 0; c < NCH; c++) begin
      act[c] = 1'b0; dv[c] = 3; sv[c] = 0; rf[c] = 0; cv[c] = 1'b0;
      plo[c] = 0; phi[c] = 0;
    end

    // Reset state, then ch0 on the default divisor of 3.
    push_win("reset", 3);
    run(3);
    rstN = 1'b1;
    en   = 5'b00001;
    start(0, 3);
    push_win("div3", 16);
    run(16);

    // Write D=0 mid half-period: old half-period completes first.
    plo[0] = e + 1; phi[0] = e + 4;
    push_win("wr_d0", 4);
    cfgWe = 1'b1; cfgChan = CW'(0); cfgDiv = 8'd0;
    run(1);
    cfgWe = 1'b0;
    run(3);
    reref(0, 0);
    push_win("div0", 8);
    run(8);

    // Write D=9 in a terminal cycle: held to the following terminal.
    plo[0] = e + 1; phi[0] = e + 2;
    push_win("wr_d9_term", 2);
    cfgWe = 1'b1; cfgDiv = 8'd9;
    run(1);
    cfgWe = 1'b0;
    run(1);
    reref(0, 9);

    // Write D=2 while cnt=5: current 10-cycle half-period still completes.
    plo[0] = e + 6; phi[0] = e + 10;
    push_win("d9_wr_d2", 10);
    run(5);
    cfgWe = 1'b1; cfgDiv = 8'd2;
    run(1);
    cfgWe = 1'b0;
    run(4);
    reref(0, 2);
    push_win("div2", 12);
    run(12);

    // ch2: D=4 then D=6 before terminal, then an out-of-range write.
    en = 5'b00101;
    start(2, 3);
    plo[2] = e + 1; phi[2] = e + 4;
    push_win("ch2_ww", 4);
    cfgWe = 1'b1; cfgChan = CW'(2); cfgDiv = 8'd4;
    run(1);
    cfgDiv = 8'd6;
    run(1);
    cfgChan = CW'(7); cfgDiv = 8'd1;
    run(1);
    cfgWe = 1'b0;
    run(1);
    reref(2, 6);
    push_win("ch2_d6", 21);
    run(21);

    // ch1: run, drop enable mid-period for 5 cycles, re-enable.
    en = 5'b00111;
    start(1, 3);
    push_win("ch1_run", 6);
    run(6);
    en = 5'b00101;
    act[1] = 1'b0;
    push_win("ch1_off", 5);
    run(5);
    en = 5'b00111;
    start(1, 3);
    push_win("ch1_reen", 10);
    run(10);

    // ch3: maximum divisor written while disabled, then enabled.
    plo[3] = e + 1; phi[3] = e + 2;
    push_win("ch3_wr_max", 2);
    cfgWe = 1'b1; cfgChan = CW'(3); cfgDiv = 8'd255;
    run(1);
    cfgWe = 1'b0;
    run(1);
    en = 5'b01111;
    start(3, 255);
    push_win("ch3_max", 520);
    run(520);

`ifdef CLK_DIV_MULTI_SYNC_EN
    // Pending D=5 on ch1 is applied by the sync pulse.
    plo[1] = e + 1; phi[1] = e + 2;
    push_win("wr_pre_sync", 1);
    cfgWe = 1'b1; cfgChan = CW'(1); cfgDiv = 8'd5;
    run(1);
    cfgWe  = 1'b0;
    syncIn = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (act[c]) begin
        rf[c] = e + 1; sv[c] = 0; cv[c] = 1'b0;
      end
    end
    dv[1] = 5;
    push_win("sync", 24);
    run(1);
    syncIn = 1'b0;
    run(23);
`endif

    // Asynchronous reset between clock edges clears outputs at once.
    cfgWe = 1'b1; cfgChan = CW'(4); cfgDiv = 8'd9;
    @(posedge clkIn);
    #1;
    cfgWe = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    chk("async_rst_clkOut",  clkOut,  {NCH{1'b0}});
    chk("async_rst_tick",    tick,    {NCH{1'b0}});
    chk("async_rst_pending", pending, {NCH{1'b0}});
    @(posedge clkIn);
    #1;
    chk("rst_hold_clkOut", clkOut, {NCH{1'b0}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
